// File: rtl/modlin_issue.sv
// modlin_issue: issue/writeback controller for the 4-cycle modular linear unit.
// Scoreboards registers so dependent instructions wait for their writeback.
`default_nettype none

`ifndef WORDSZ
`define WORDSZ 16
`endif
`ifndef RFSZLOG2
`define RFSZLOG2 4
`endif

module modlin_issue #(
    parameter int WORDSZ   = `WORDSZ,
    parameter int RFSZLOG2 = `RFSZLOG2,
    parameter int LAT      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ins_valid,
    output logic                ins_ready,
    input  logic [1:0]          ins_op,
    input  logic [RFSZLOG2-1:0] ins_ra,
    input  logic [RFSZLOG2-1:0] ins_rb,
    input  logic [RFSZLOG2-1:0] ins_rd,
    output logic [RFSZLOG2-1:0] rf_raddr_a,
    output logic [RFSZLOG2-1:0] rf_raddr_b,
    input  logic [WORDSZ-1:0]   rf_rdata_a,
    input  logic [WORDSZ-1:0]   rf_rdata_b,
    output logic                rf_we,
    output logic [RFSZLOG2-1:0] rf_waddr,
    output logic [WORDSZ-1:0]   rf_wdata,
    output logic                lin_en,
    output logic [WORDSZ-1:0]   lin_a,
    output logic [WORDSZ-1:0]   lin_b,
    output logic [RFSZLOG2-1:0] lin_rn,
    output logic [1:0]          lin_op,
    input  logic [RFSZLOG2-1:0] lin_rnq,
    input  logic [WORDSZ-1:0]   lin_res,
    output logic                busy
);

    localparam int c_NREG = 2**RFSZLOG2;

    logic [c_NREG-1:0]   r_pend;
    logic [LAT:0]        r_track;
    logic                r_s1_valid;
    logic [1:0]          r_s1_op;
    logic [RFSZLOG2-1:0] r_s1_rd;

    logic                w_hazard;
    logic                w_fire;
    logic [c_NREG-1:0]   w_set;
    logic [c_NREG-1:0]   w_clr;
    logic [c_NREG-1:0]   w_pend_nxt;

    // rb only matters for the two-operand ops (add/sub have op[1] set)
    always_comb begin
        w_hazard = r_pend[ins_ra]
                 | (ins_op[1] & r_pend[ins_rb])
                 | ((ins_rd != '0) & r_pend[ins_rd]);
    end

    assign ins_ready  = rst_n & ~w_hazard;
    assign w_fire     = ins_valid & ins_ready;
    assign rf_raddr_a = ins_ra;
    assign rf_raddr_b = ins_rb;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_fire && (ins_rd != '0)) begin
            w_set[ins_rd] = 1'b1;
        end
        if (lin_rnq != '0) begin
            w_clr[lin_rnq] = 1'b1;
        end
        w_pend_nxt = (r_pend & ~w_clr) | w_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_track    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_rd    <= '0;
        end else begin
            r_pend     <= {w_pend_nxt[c_NREG-1:1], 1'b0};
            r_track    <= {r_track[LAT-1:0], w_fire};
            r_s1_valid <= w_fire;
            r_s1_op    <= w_fire ? ins_op : 2'b00;
            r_s1_rd    <= w_fire ? ins_rd : '0;
        end
    end

    // Read data arrives the cycle after the handshake, aligned with stage 1
    assign lin_en = r_s1_valid;
    assign lin_a  = r_s1_valid ? rf_rdata_a : '0;
    assign lin_b  = r_s1_valid ? rf_rdata_b : '0;
    assign lin_rn = r_s1_rd;
    assign lin_op = r_s1_op;

    assign rf_we    = (lin_rnq != '0);
    assign rf_waddr = lin_rnq;
    assign rf_wdata = lin_res;

    assign busy = (|r_track) | (|r_pend);

`ifndef SYNTHESIS
    // WAW stalling makes a same-cycle set/clear of one register impossible
    always @(posedge clk) begin
        if (rst_n) begin
            assert ((w_set & w_clr) == '0);
            assert ((w_clr & ~r_pend) == '0);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_modlin_issue.sv
// tb_modlin_issue: directed bench with register-file and linear-unit models
// and a writeback scoreboard for modlin_issue.
`default_nettype none

module tb_modlin_issue;

    localparam int W   = 8;
    localparam int A   = 3;
    localparam int LAT = 4;
    localparam int P   = 251;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ins_valid, ins_ready;
    logic [1:0]   ins_op;
    logic [A-1:0] ins_ra, ins_rb, ins_rd;
    logic [A-1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [W-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic         rf_we, lin_en, busy;
    logic [W-1:0] lin_a, lin_b, lin_res;
    logic [A-1:0] lin_rn, lin_rnq;
    logic [1:0]   lin_op;

    always #5 clk = ~clk;

    modlin_issue #(.WORDSZ(W), .RFSZLOG2(A), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op),
        .ins_ra(ins_ra), .ins_rb(ins_rb), .ins_rd(ins_rd),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .lin_en(lin_en), .lin_a(lin_a), .lin_b(lin_b), .lin_rn(lin_rn), .lin_op(lin_op),
        .lin_rnq(lin_rnq), .lin_res(lin_res), .busy(busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;

    function automatic logic [W-1:0] modlin(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        case (op)
            2'd0:    s = (a == 0) ? 0 : P - int'(a);
            2'd1:    s = (2 * int'(a)) % P;
            2'd2:    s = (int'(a) + int'(b)) % P;
            default: s = (int'(a) + P - int'(b)) % P;
        endcase
        return s[W-1:0];
    endfunction

    // Register file: synchronous read, written by preload or by the DUT
    logic [W-1:0] rf [8];
    logic         pl_we = 1'b0;
    logic [A-1:0] pl_addr = '0;
    logic [W-1:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_we) rf[pl_addr] <= pl_data;
        else if (rf_we) rf[rf_waddr] <= rf_wdata;
        rf_rdata_a <= rf[rf_raddr_a];
        rf_rdata_b <= rf[rf_raddr_b];
    end

    // Linear unit: LAT-stage pipeline, reset clears rn
    logic [A-1:0] u_rn  [LAT];
    logic [W-1:0] u_res [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                u_rn[i]  <= '0;
                u_res[i] <= '0;
            end
        end else begin
            u_rn[0]  <= lin_en ? lin_rn : '0;
            u_res[0] <= lin_en ? modlin(lin_op, lin_a, lin_b) : '0;
            for (int i = 1; i < LAT; i++) begin
                u_rn[i]  <= u_rn[i-1];
                u_res[i] <= u_res[i-1];
            end
        end
    end
    assign lin_rnq = u_rn[LAT-1];
    assign lin_res = u_res[LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [A-1:0] rd;
        logic [W-1:0] val;
        int           when;
    } exp_t;
    exp_t         sb[$];
    logic [W-1:0] gold [8];

    exp_t mon_e;
    always @(negedge clk) begin
        if (rf_we || (sb.size() != 0 && sb[0].when == cyc)) begin
            if (sb.size() == 0) begin
                check("spurious_we", 32'(rf_we), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_cycle", cyc, mon_e.when);
                check("wb_we", 32'(rf_we), 32'd1);
                check("wb_addr", 32'(rf_waddr), 32'(mon_e.rd));
                check("wb_data", 32'(rf_wdata), 32'(mon_e.val));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int r, input int v);
        pl_we   = 1'b1;
        pl_addr = r[A-1:0];
        pl_data = v[W-1:0];
        gold[r] = v[W-1:0];
        step();
        pl_we = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge ending the handshake
    task automatic issue(input logic [1:0] op, input int ra, input int rb, input int rd,
                         output int tcyc, output int stalls);
        exp_t e;
        ins_valid = 1'b1;
        ins_op    = op;
        ins_ra    = ra[A-1:0];
        ins_rb    = rb[A-1:0];
        ins_rd    = rd[A-1:0];
        stalls    = 0;
        tcyc      = -1;
        @(negedge clk);
        while (!ins_ready && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        if (!ins_ready) begin
            vecs++;
            errs++;
            $error("FAIL issue_timeout: observed ready %0b expected 1", ins_ready);
        end else begin
            tcyc = cyc;
            e.rd   = rd[A-1:0];
            e.val  = modlin(op, gold[ra], gold[rb]);
            e.when = cyc + 1 + LAT;
            if (rd != 0) begin
                gold[rd] = e.val;
                sb.push_back(e);
            end
        end
        step();
        ins_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < 60) begin
            n++;
            @(negedge clk);
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sb", sb.size(), 32'd0);
    endtask

    initial begin
        int t0, t1, t2, st;
        logic [W-1:0] sav [8];

        ins_valid = 1'b0;
        ins_op    = '0;
        ins_ra    = '0;
        ins_rb    = '0;
        ins_rd    = '0;

        // Reset state, register file preloaded meanwhile
        preload(0, 0); preload(1, 5); preload(2, 7); preload(3, 8'h30);
        preload(4, 8'h40); preload(5, 8'h50); preload(6, 8'h60); preload(7, 9);
        @(negedge clk);
        check("rst_ready", 32'(ins_ready), 32'd0);
        check("rst_lin_en", 32'(lin_en), 32'd0);
        check("rst_lin_a", 32'(lin_a), 32'd0);
        check("rst_lin_b", 32'(lin_b), 32'd0);
        check("rst_lin_rn", 32'(lin_rn), 32'd0);
        check("rst_lin_op", 32'(lin_op), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(ins_ready), 32'd1);
        check("idle_lin_en", 32'(lin_en), 32'd0);
        step();

        // Independent back-to-back stream
        issue(2'd2, 1, 2, 3, t0, st);
        issue(2'd3, 2, 1, 4, t1, st);
        check("b2b_cycle", t1, t0 + 1);
        check("b2b_stalls", st, 32'd0);
        wait_cyc(t0 + 6);
        check("busy_t6", 32'(busy), 32'd1);
        wait_cyc(t0 + 7);
        check("busy_t7", 32'(busy), 32'd0);
        step();

        // RAW stall: dbl depends on add's destination
        issue(2'd2, 1, 2, 3, t0, st);
        issue(2'd1, 3, 0, 5, t1, st);
        check("raw_cycle", t1, t0 + 6);
        check("raw_stalls", st, 32'd5);
        wait_idle();
        step();

        // rb is ignored for neg/dbl; neg of R0 yields 0
        issue(2'd2, 1, 1, 2, t0, st);
        issue(2'd0, 1, 2, 6, t1, st);
        check("neg_rb_cycle", t1, t0 + 1);
        issue(2'd0, 0, 0, 7, t2, st);
        check("neg_r0_stalls", st, 32'd0);
        wait_idle();
        step();

        // WAW stall, then an rd=0 instruction that must not write back
        issue(2'd2, 1, 2, 3, t0, st);
        issue(2'd2, 2, 2, 3, t1, st);
        check("waw_cycle", t1, t0 + 6);
        issue(2'd2, 1, 2, 0, t2, st);
        check("rd0_stalls", st, 32'd0);
        @(negedge clk);
        check("rd0_lin_en", 32'(lin_en), 32'd1);
        check("rd0_lin_rn", 32'(lin_rn), 32'd0);
        check("rd0_lin_op", 32'(lin_op), 32'd2);
        check("rd0_lin_a", 32'(lin_a), 32'(gold[1]));
        check("rd0_lin_b", 32'(lin_b), 32'(gold[2]));
        @(negedge clk);
        check("rd0_lin_en_end", 32'(lin_en), 32'd0);
        wait_idle();
        step();

        // Reset with three instructions in flight
        for (int i = 0; i < 8; i++) sav[i] = gold[i];
        issue(2'd2, 1, 1, 3, t0, st);
        issue(2'd3, 1, 2, 4, t1, st);
        issue(2'd1, 2, 0, 5, t2, st);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(ins_ready), 32'd0);
        check("mid_rst_lin_en", 32'(lin_en), 32'd0);
        check("mid_rst_rf_we", 32'(rf_we), 32'd0);
        sb.delete();
        for (int i = 0; i < 8; i++) gold[i] = sav[i];
        step();
        rst_n = 1'b1;
        issue(2'd2, 3, 4, 3, t0, st);
        check("post_rst_stalls", st, 32'd0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $error("FAIL global_timeout: observed cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
